// File: rtl/mul_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mul_pkg
// Description : Shared types and default sizes for the mul_sched scheduler.
// Revision    : 1.0
// ============================================================================
package mul_pkg;

    localparam int DEF_N    = 8;
    localparam int DEF_NREQ = 4;

    typedef enum logic {OP_MUL, OP_ADD} mul_op_t;

    typedef enum logic {ST_EMPTY, ST_FULL} rsp_state_t;

endpackage
`default_nettype wire

// File: rtl/mul_sched_if.sv
`default_nettype none
// ============================================================================
// Module      : mul_sched_if
// Description : Requester and result-side signals of the shared multiplier.
// Revision    : 1.0
// ============================================================================
interface mul_sched_if
    import mul_pkg::*;
#(
    parameter int n    = DEF_N,
    parameter int NREQ = DEF_NREQ,
    parameter int IDW  = $clog2(NREQ)
);
    logic [NREQ-1:0]        req_valid;
    logic [NREQ-1:0]        req_ready;
    logic [NREQ-1:0]        req_op;
    logic [NREQ-1:0][n-1:0] req_a;
    logic [NREQ-1:0][n-1:0] req_b;
    logic                   rsp_valid;
    logic                   rsp_ready;
    logic [IDW-1:0]         rsp_id;
    logic [n-1:0]           rsp_data;
    logic                   busy;

    modport master (
        output req_valid, req_op, req_a, req_b, rsp_ready,
        input  req_ready, rsp_valid, rsp_id, rsp_data, busy
    );

    modport slave (
        input  req_valid, req_op, req_a, req_b, rsp_ready,
        output req_ready, rsp_valid, rsp_id, rsp_data, busy
    );
endinterface
`default_nettype wire

// File: rtl/mult.sv
`default_nettype none
// ============================================================================
// Module      : mult
// Description : Shared W x W multiplier returning the low W product bits.
// Revision    : 1.0
// ============================================================================
module mult #(
    parameter int W = 16
) (
    input  wire logic [W-1:0] i_a,
    input  wire logic [W-1:0] i_b,
    output logic      [W-1:0] o_p
);

    assign o_p = i_a * i_b;

endmodule
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : rr_arbiter
// Description : Combinational round-robin arbiter searching upward from i_ptr.
// Revision    : 1.0
// ============================================================================
module rr_arbiter #(
    parameter int NREQ = 4,
    parameter int IDW  = $clog2(NREQ)
) (
    input  wire logic [NREQ-1:0] i_req,
    input  wire logic [IDW-1:0]  i_ptr,
    input  wire logic            i_en,
    output logic      [NREQ-1:0] o_gnt,
    output logic      [IDW-1:0]  o_idx
);

    int             w_pos;
    logic [IDW-1:0] w_pos_idx;
    logic           w_found;

    // The winner index is resolved even when disabled; only the grant is gated.
    always_comb begin
        o_gnt     = '0;
        o_idx     = '0;
        w_found   = 1'b0;
        w_pos     = 0;
        w_pos_idx = '0;
        for (int k = 0; k < NREQ; k++) begin
            w_pos = int'(i_ptr) + k;
            if (w_pos >= NREQ) begin
                w_pos = w_pos - NREQ;
            end
            w_pos_idx = IDW'(w_pos);
            if (!w_found && i_req[w_pos_idx]) begin
                w_found = 1'b1;
                o_idx   = w_pos_idx;
            end
        end
        if (w_found && i_en) begin
            o_gnt[o_idx] = 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/mul_sched.sv
`default_nettype none
// ============================================================================
// Module      : mul_sched
// Description : Round-robin sharing of one multiplier among NREQ requesters,
//               with a single-entry result register and backpressure.
// Revision    : 1.0
// ============================================================================
module mul_sched
    import mul_pkg::*;
#(
    parameter int n    = DEF_N,
    parameter int NREQ = DEF_NREQ,
    parameter int IDW  = $clog2(NREQ)
) (
    input  wire logic clk,
    input  wire logic reset,
    mul_sched_if.slave bus
);

    localparam logic [n-1:0] c_ONE = {{(n-1){1'b0}}, 1'b1};

    rsp_state_t     r_state;
    logic [IDW-1:0] r_rr_ptr;
    logic [IDW-1:0] r_rsp_id;
    logic [n-1:0]   r_rsp_data;

    logic [NREQ-1:0] w_gnt;
    logic [IDW-1:0]  w_idx;
    logic [IDW-1:0]  w_ptr_nxt;
    logic            w_arb_en;
    logic            w_xfer;
    mul_op_t         w_op;
    logic [n-1:0]    w_a;
    logic [n-1:0]    w_b;
    logic [2*n-1:0]  w_mul_a;
    logic [2*n-1:0]  w_mul_b;
    logic [2*n-1:0]  w_prod;
    logic [n-1:0]    w_result;

    assign w_arb_en = ((r_state == ST_EMPTY) || bus.rsp_ready) && !reset;

    rr_arbiter #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_arb (
        .i_req (bus.req_valid),
        .i_ptr (r_rr_ptr),
        .i_en  (w_arb_en),
        .o_gnt (w_gnt),
        .o_idx (w_idx)
    );

    assign bus.req_ready = w_gnt;
    assign w_xfer        = |(w_gnt & bus.req_valid);
    assign w_ptr_nxt     = (w_idx == IDW'(NREQ - 1)) ? '0 : w_idx + 1'b1;

    assign w_op = mul_op_t'(bus.req_op[w_idx]);
    assign w_a  = bus.req_a[w_idx];
    assign w_b  = bus.req_b[w_idx];

    // ADD: {A,B} * {1,1} puts A+B (mod 2^n) in the upper half of the low 2n bits.
    always_comb begin
        w_mul_a = {{n{w_a[n-1]}}, w_a};
        w_mul_b = {{n{w_b[n-1]}}, w_b};
        if (w_op == OP_ADD) begin
            w_mul_a = {w_a, w_b};
            w_mul_b = {c_ONE, c_ONE};
        end
    end

    mult #(
        .W (2*n)
    ) u_mult (
        .i_a (w_mul_a),
        .i_b (w_mul_b),
        .o_p (w_prod)
    );

    assign w_result = (w_op == OP_ADD) ? w_prod[2*n-1:n] : w_prod[n-1:0];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= ST_EMPTY;
            r_rr_ptr   <= '0;
            r_rsp_id   <= '0;
            r_rsp_data <= '0;
        end else begin
            if (w_xfer) begin
                r_rr_ptr   <= w_ptr_nxt;
                r_rsp_id   <= w_idx;
                r_rsp_data <= w_result;
            end
            case (r_state)
                ST_EMPTY: begin
                    if (w_xfer) begin
                        r_state <= ST_FULL;
                    end
                end
                ST_FULL: begin
                    if (bus.rsp_ready && !w_xfer) begin
                        r_state <= ST_EMPTY;
                    end
                end
                default: r_state <= ST_EMPTY;
            endcase
        end
    end

    assign bus.rsp_valid = (r_state == ST_FULL);
    assign bus.rsp_id    = r_rsp_id;
    assign bus.rsp_data  = r_rsp_data;
    assign bus.busy      = (r_state == ST_FULL) && !bus.rsp_ready;

endmodule
`default_nettype wire

// File: tb/tb_mul_sched.sv
`default_nettype none
// ============================================================================
// Module      : tb_mul_sched
// Description : Self-checking bench for mul_sched (vector table + sequences).
// Revision    : 1.0
// ============================================================================
module tb_mul_sched;

    logic clk;
    logic reset;

    mul_sched_if #(.n(8), .NREQ(4)) bus ();

    mul_sched #(.n(8), .NREQ(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]      valid;
        logic [3:0]      op;
        logic [3:0][7:0] a;
        logic [3:0][7:0] b;
        logic            rdy;
        logic [3:0]      e_ready;
        logic            e_busy;
        logic            e_valid;
        logic [1:0]      e_id;
        logic [7:0]      e_data;
    } vec_t;

    vec_t tbl [16];
    int   n_vec;
    int   n_err;

    localparam logic [31:0] A4 = {8'h00, 8'h7F, 8'hFE, 8'h02};
    localparam logic [31:0] B4 = {8'h37, 8'h01, 8'h05, 8'h03};

    function automatic vec_t mk(logic [3:0] valid, logic [3:0] op, logic [31:0] a,
                                logic [31:0] b, logic rdy, logic [3:0] e_ready,
                                logic e_busy, logic e_valid, logic [1:0] e_id,
                                logic [7:0] e_data);
        vec_t v;
        v.valid = valid; v.op = op; v.a = a; v.b = b; v.rdy = rdy;
        v.e_ready = e_ready; v.e_busy = e_busy; v.e_valid = e_valid;
        v.e_id = e_id; v.e_data = e_data;
        return v;
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(logic [3:0] valid, logic [3:0] op, logic [31:0] a,
                         logic [31:0] b, logic rdy);
        bus.req_valid = valid;
        bus.req_op    = op;
        bus.req_a     = a;
        bus.req_b     = b;
        bus.rsp_ready = rdy;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        drive(4'b0000, 4'b0000, 32'h0, 32'h0, 1'b0);
        tick();
        tick();
        reset = 1'b0;
    endtask

    // Round-robin / wrap-arithmetic reference for the random section.
    logic       m_full;
    logic [1:0] m_ptr, m_id;
    logic [7:0] m_data;

    initial begin
        n_vec = 0;
        n_err = 0;
        reset = 1'b1;
        drive(4'b1111, 4'b0000, A4, B4, 1'b1);
        tick();
        n_vec++;
        chk("reset_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        chk("reset_rsp_id",    32'(bus.rsp_id),    32'd0);
        chk("reset_rsp_data",  32'(bus.rsp_data),  32'd0);
        chk("reset_req_ready", 32'(bus.req_ready), 32'd0);
        chk("reset_busy",      32'(bus.busy),      32'd0);
        reset = 1'b0;
        drive(4'b0000, 4'b0000, 32'h0, 32'h0, 1'b1);

        tbl[0]  = mk(4'b0001, 4'b0000, 32'h03, 32'hFC, 1, 4'b0001, 0, 1, 0, 8'hF4);
        tbl[1]  = mk(4'b0010, 4'b0010, 32'h6400, 32'h6400, 1, 4'b0010, 0, 1, 1, 8'hC8);
        tbl[2]  = mk(4'b0010, 4'b0000, 32'h1000, 32'h1000, 1, 4'b0010, 0, 1, 1, 8'h00);
        tbl[3]  = mk(4'b0000, 4'b0000, 32'h0, 32'h0, 1, 4'b0000, 0, 0, 0, 8'h00);
        tbl[4]  = mk(4'b1111, 4'b0100, A4, B4, 1, 4'b0100, 0, 1, 2, 8'h80);
        tbl[5]  = mk(4'b1111, 4'b0100, A4, B4, 1, 4'b1000, 0, 1, 3, 8'h00);
        tbl[6]  = mk(4'b1111, 4'b0100, A4, B4, 1, 4'b0001, 0, 1, 0, 8'h06);
        tbl[7]  = mk(4'b1111, 4'b0100, A4, B4, 1, 4'b0010, 0, 1, 1, 8'hF6);
        tbl[8]  = mk(4'b1111, 4'b0100, A4, B4, 0, 4'b0000, 1, 1, 1, 8'hF6);
        tbl[9]  = mk(4'b1111, 4'b0100, A4, B4, 1, 4'b0100, 0, 1, 2, 8'h80);
        tbl[10] = mk(4'b0011, 4'b0100, A4, B4, 1, 4'b0001, 0, 1, 0, 8'h06);
        tbl[11] = mk(4'b0001, 4'b0100, A4, B4, 0, 4'b0000, 1, 1, 0, 8'h06);
        tbl[12] = mk(4'b0001, 4'b0100, A4, B4, 1, 4'b0001, 0, 1, 0, 8'h06);
        tbl[13] = mk(4'b0000, 4'b0100, A4, B4, 0, 4'b0000, 1, 1, 0, 8'h06);
        tbl[14] = mk(4'b0000, 4'b0100, A4, B4, 1, 4'b0000, 0, 0, 0, 8'h00);
        tbl[15] = mk(4'b1000, 4'b0100, A4, B4, 0, 4'b1000, 0, 1, 3, 8'h00);

        for (int i = 0; i < 16; i++) begin
            drive(tbl[i].valid, tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].rdy);
            #1;
            n_vec++;
            chk($sformatf("tbl%0d_req_ready", i), 32'(bus.req_ready), 32'(tbl[i].e_ready));
            chk($sformatf("tbl%0d_busy", i),      32'(bus.busy),      32'(tbl[i].e_busy));
            tick();
            chk($sformatf("tbl%0d_rsp_valid", i), 32'(bus.rsp_valid), 32'(tbl[i].e_valid));
            if (tbl[i].e_valid) begin
                chk($sformatf("tbl%0d_rsp_id", i),   32'(bus.rsp_id),   32'(tbl[i].e_id));
                chk($sformatf("tbl%0d_rsp_data", i), 32'(bus.rsp_data), 32'(tbl[i].e_data));
            end
        end

        // Fairness: all requesters held valid, grants must rotate from 0.
        do_reset();
        drive(4'b1111, 4'b0100, A4, B4, 1'b1);
        for (int c = 0; c < 8; c++) begin
            #1;
            n_vec++;
            chk($sformatf("fair%0d_req_ready", c), 32'(bus.req_ready), 32'(1) << (c % 4));
            tick();
            chk($sformatf("fair%0d_rsp_id", c), 32'(bus.rsp_id), 32'(c % 4));
        end

        // Backpressure: result held, req2 waits until rsp_ready returns.
        do_reset();
        drive(4'b0001, 4'b0100, 32'h03, 32'hFC, 1'b1);
        tick();
        n_vec++;
        chk("bp_first_data", 32'(bus.rsp_data), 32'hF4);
        drive(4'b0100, 4'b0100, A4, B4, 1'b0);
        for (int c = 0; c < 3; c++) begin
            #1;
            n_vec++;
            chk($sformatf("bp%0d_req_ready", c), 32'(bus.req_ready), 32'd0);
            chk($sformatf("bp%0d_busy", c),      32'(bus.busy),      32'd1);
            tick();
            chk($sformatf("bp%0d_rsp_data", c),  32'(bus.rsp_data),  32'hF4);
            chk($sformatf("bp%0d_rsp_id", c),    32'(bus.rsp_id),    32'd0);
        end
        bus.rsp_ready = 1'b1;
        #1;
        n_vec++;
        chk("bp_release_req_ready", 32'(bus.req_ready), 32'b0100);
        tick();
        chk("bp_release_rsp_id",   32'(bus.rsp_id),   32'd2);
        chk("bp_release_rsp_data", 32'(bus.rsp_data), 32'h80);

        // Asynchronous reset mid-cycle while FULL.
        drive(4'b1010, 4'b0100, A4, B4, 1'b1);
        #2;
        reset = 1'b1;
        #1;
        n_vec++;
        chk("areset_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        chk("areset_req_ready", 32'(bus.req_ready), 32'd0);
        #1;
        reset = 1'b0;
        #1;
        chk("areset_first_grant", 32'(bus.req_ready), 32'b0010);
        tick();
        chk("areset_rsp_id",   32'(bus.rsp_id),   32'd1);
        chk("areset_rsp_data", 32'(bus.rsp_data), 32'hF6);

        // Random regression against the reference model.
        do_reset();
        m_full = 1'b0;
        m_ptr  = 2'd0;
        m_id   = 2'd0;
        m_data = 8'd0;
        for (int cyc = 0; cyc < 2000; cyc++) begin
            logic [3:0] e_rdy;
            logic       en;
            logic       won;
            logic [1:0] w;
            drive(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                  $urandom, $urandom, ($urandom_range(0, 9) < 7));
            #1;
            n_vec++;
            en    = !m_full || bus.rsp_ready;
            won   = 1'b0;
            w     = 2'd0;
            e_rdy = 4'b0000;
            for (int k = 0; k < 4; k++) begin
                logic [1:0] p;
                p = 2'(int'(m_ptr) + k);
                if (!won && bus.req_valid[p]) begin
                    won = 1'b1;
                    w   = p;
                end
            end
            if (won && en) e_rdy[w] = 1'b1;
            chk($sformatf("rnd%0d_req_ready", cyc), 32'(bus.req_ready), 32'(e_rdy));
            chk($sformatf("rnd%0d_busy", cyc), 32'(bus.busy), 32'(m_full && !bus.rsp_ready));
            if (won && en) begin
                m_full = 1'b1;
                m_id   = w;
                m_data = bus.req_op[w] ? 8'(bus.req_a[w] + bus.req_b[w])
                                       : 8'(bus.req_a[w] * bus.req_b[w]);
                m_ptr  = w + 2'd1;
            end else if (bus.rsp_ready) begin
                m_full = 1'b0;
            end
            tick();
            chk($sformatf("rnd%0d_rsp_valid", cyc), 32'(bus.rsp_valid), 32'(m_full));
            if (m_full) begin
                chk($sformatf("rnd%0d_rsp_id", cyc),   32'(bus.rsp_id),   32'(m_id));
                chk($sformatf("rnd%0d_rsp_data", cyc), 32'(bus.rsp_data), 32'(m_data));
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
